// File: rtl/btn_step_conditioner_if.sv
// Pushbutton conditioner signal bundle: raw button in, debounced level and strobes out.
// Strobes are single-cycle, registered, and need no acknowledge; dbgState mirrors the FSM.
interface btn_step_conditioner_if;
  logic       btnRaw;
  logic       btnLevel;
  logic       pressPulse;
  logic       releasePulse;
  logic       stepPulse;
  logic [1:0] dbgState;

  modport master (
    output btnRaw,
    input  btnLevel, pressPulse, releasePulse, stepPulse, dbgState
  );

  modport slave (
    input  btnRaw,
    output btnLevel, pressPulse, releasePulse, stepPulse, dbgState
  );
endinterface

// File: rtl/btn_step_conditioner.sv
// Synchronises and debounces one raw pushbutton, emitting press/release/step strobes
// with optional auto-repeat of the step strobe while the button is held.
module btn_step_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned REPEAT_EN       = 1,
  parameter int unsigned REPEAT_DELAY    = 50_000_000,
  parameter int unsigned REPEAT_PERIOD   = 20_000_000
) (
  input  logic                          clk,
  input  logic                          resetN,
  btn_step_conditioner_if.slave         btn_if
);

  localparam int unsigned HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned HW       = $clog2(HOLD_MAX + 1);
  localparam int unsigned DW       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] DELAY_V  = HW'(REPEAT_DELAY);
  localparam logic [HW-1:0] PERIOD_V = HW'(REPEAT_PERIOD);
  localparam logic [HW-1:0] HOLD_SAT = HW'(HOLD_MAX);

  localparam logic [1:0] ST_RELEASED     = 2'd0;
  localparam logic [1:0] ST_PRESS_PEND   = 2'd1;
  localparam logic [1:0] ST_PRESSED      = 2'd2;
  localparam logic [1:0] ST_RELEASE_PEND = 2'd3;

  logic          sync1_q, btn_sync_q;
  logic [1:0]    state_q, state_d;
  logic [DW-1:0] db_cnt_q, db_cnt_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d, hold_inc;
  logic          rep_q, rep_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          step_q, step_d;

  always_comb begin
    state_d    = state_q;
    db_cnt_d   = db_cnt_q;
    hold_cnt_d = hold_cnt_q;
    rep_d      = rep_q;
    press_d    = 1'b0;
    release_d  = 1'b0;
    step_d     = 1'b0;
    hold_inc   = hold_cnt_q + HW'(1);

    case (state_q)
      ST_RELEASED: begin
        if (btn_sync_q) begin
          state_d  = ST_PRESS_PEND;
          db_cnt_d = '0;
        end
      end
      ST_PRESS_PEND: begin
        if (!btn_sync_q) begin
          state_d = ST_RELEASED;
        end else if (db_cnt_q == DB_LAST) begin
          state_d    = ST_PRESSED;
          hold_cnt_d = '0;
          rep_d      = 1'b0;
          press_d    = 1'b1;
          step_d     = 1'b1;
        end else begin
          db_cnt_d = db_cnt_q + DW'(1);
        end
      end
      ST_PRESSED: begin
        if (!btn_sync_q) begin
          state_d  = ST_RELEASE_PEND;
          db_cnt_d = '0;
        end else if (REPEAT_EN != 0) begin
          // rep_q selects the interval: first the long delay, then the shorter period
          if (hold_inc == (rep_q ? PERIOD_V : DELAY_V)) begin
            step_d     = 1'b1;
            hold_cnt_d = '0;
            rep_d      = 1'b1;
          end else begin
            hold_cnt_d = hold_inc;
          end
        end else if (hold_cnt_q != HOLD_SAT) begin
          hold_cnt_d = hold_inc;
        end
      end
      ST_RELEASE_PEND: begin
        if (btn_sync_q) begin
          state_d    = ST_PRESSED;
          hold_cnt_d = '0;
          rep_d      = 1'b0;
        end else if (db_cnt_q == DB_LAST) begin
          state_d   = ST_RELEASED;
          release_d = 1'b1;
        end else begin
          db_cnt_d = db_cnt_q + DW'(1);
        end
      end
      default: state_d = ST_RELEASED;
    endcase

    level_d = (state_d == ST_PRESSED) || (state_d == ST_RELEASE_PEND);
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      sync1_q    <= 1'b0;
      btn_sync_q <= 1'b0;
      state_q    <= ST_RELEASED;
      db_cnt_q   <= '0;
      hold_cnt_q <= '0;
      rep_q      <= 1'b0;
      level_q    <= 1'b0;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
      step_q     <= 1'b0;
    end else begin
      sync1_q    <= btn_if.btnRaw;
      btn_sync_q <= sync1_q;
      state_q    <= state_d;
      db_cnt_q   <= db_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      rep_q      <= rep_d;
      level_q    <= level_d;
      press_q    <= press_d;
      release_q  <= release_d;
      step_q     <= step_d;
    end
  end

  assign btn_if.btnLevel     = level_q;
  assign btn_if.pressPulse   = press_q;
  assign btn_if.releasePulse = release_q;
  assign btn_if.stepPulse    = step_q;
  assign btn_if.dbgState     = state_q;

endmodule

// File: tb/tb_btn_step_conditioner.sv
// Bench for btn_step_conditioner: one instance without and one with auto-repeat,
// sharing the button and reset; strobe events are checked against a timed expected queue.
module tb_btn_step_conditioner;

  localparam int DC = 4;
  localparam int RD = 10;
  localparam int RP = 3;
  localparam int W  = 19;

  logic clk = 1'b0;
  logic resetN;
  logic raw;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  logic [W-1:0] exp0_q[$];
  logic [W-1:0] exp1_q[$];

  btn_step_conditioner_if bus0 ();
  btn_step_conditioner_if bus1 ();
  assign bus0.btnRaw = raw;
  assign bus1.btnRaw = raw;

  btn_step_conditioner #(
    .DEBOUNCE_CYCLES(DC), .REPEAT_EN(0), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut0 (
    .clk(clk), .resetN(resetN), .btn_if(bus0.slave)
  );

  btn_step_conditioner #(
    .DEBOUNCE_CYCLES(DC), .REPEAT_EN(1), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut1 (
    .clk(clk), .resetN(resetN), .btn_if(bus1.slave)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic push(input int which, input int c, input logic p, input logic r, input logic s);
    logic [W-1:0] v;
    v = {16'(c), p, r, s};
    if (which == 0) exp0_q.push_back(v);
    else            exp1_q.push_back(v);
  endtask

  task automatic push_both(input int c, input logic p, input logic r, input logic s);
    push(0, c, p, r, s);
    push(1, c, p, r, s);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic chk_level(input string tag, input logic e);
    check_eq({tag, "_lvl0"}, {18'b0, bus0.btnLevel}, {18'b0, e});
    check_eq({tag, "_lvl1"}, {18'b0, bus1.btnLevel}, {18'b0, e});
  endtask

  task automatic chk_idle(input string tag);
    check_eq({tag, "_out0"}, {13'b0, bus0.dbgState, bus0.btnLevel, bus0.pressPulse,
                              bus0.releasePulse, bus0.stepPulse}, '0);
    check_eq({tag, "_out1"}, {13'b0, bus1.dbgState, bus1.btnLevel, bus1.pressPulse,
                              bus1.releasePulse, bus1.stepPulse}, '0);
  endtask

  // scoreboard: every observed strobe must match the next expected timed event
  always @(negedge clk) begin
    logic [W-1:0] obs;
    if ((bus0.pressPulse | bus0.releasePulse | bus0.stepPulse) === 1'b1) begin
      obs = {16'(cyc), bus0.pressPulse, bus0.releasePulse, bus0.stepPulse};
      if (exp0_q.size() == 0) check_eq("evt0_extra", obs, '0);
      else                    check_eq("evt0", obs, exp0_q.pop_front());
    end
    if ((bus1.pressPulse | bus1.releasePulse | bus1.stepPulse) === 1'b1) begin
      obs = {16'(cyc), bus1.pressPulse, bus1.releasePulse, bus1.stepPulse};
      if (exp1_q.size() == 0) check_eq("evt1_extra", obs, '0);
      else                    check_eq("evt1", obs, exp1_q.pop_front());
    end
  end

  initial begin
    int e, f, g, r;
    resetN = 1'b0;
    raw    = 1'b1;

    // reset held 3 cycles with the button pressed
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_idle("reset");
    end
    raw    = 1'b0;
    resetN = 1'b1;
    wait_until(cyc + 5);

    // clean press, auto-repeat on dut1, release before the next repeat
    @(negedge clk);
    e = cyc + 1;
    raw = 1'b1;
    push_both(e + DC + 2, 1'b1, 1'b0, 1'b1);
    push(1, e + DC + 2 + RD, 1'b0, 1'b0, 1'b1);
    push(1, e + DC + 2 + RD + RP, 1'b0, 1'b0, 1'b1);
    push(1, e + DC + 2 + RD + 2 * RP, 1'b0, 1'b0, 1'b1);
    wait_until(e + 5);
    chk_level("press_pre", 1'b0);
    wait_until(e + 6);
    chk_level("press_post", 1'b1);
    wait_until(e + 22);
    raw = 1'b0;
    f = e + 23;
    push_both(f + DC + 2, 1'b0, 1'b1, 1'b0);
    wait_until(f + 5);
    chk_level("rel_pre", 1'b1);
    wait_until(f + 6);
    chk_level("rel_post", 1'b0);
    wait_until(f + 10);

    // glitch: 3 cycles high never qualifies
    @(negedge clk);
    g = cyc + 1;
    raw = 1'b1;
    wait_until(g + 2);
    raw = 1'b0;
    wait_until(g + 12);
    chk_level("glitch", 1'b0);

    // 2-cycle dropout while pressed restarts the repeat delay, no release
    @(negedge clk);
    e = cyc + 1;
    raw = 1'b1;
    push_both(e + 6, 1'b1, 1'b0, 1'b1);
    push(1, e + 12 + RD, 1'b0, 1'b0, 1'b1);
    wait_until(e + 7);
    raw = 1'b0;
    wait_until(e + 9);
    raw = 1'b1;
    wait_until(e + 11);
    chk_level("dropout_mid", 1'b1);
    wait_until(e + 13);
    chk_level("dropout_after", 1'b1);
    wait_until(e + 22);
    raw = 1'b0;
    f = e + 23;
    push_both(f + 6, 1'b0, 1'b1, 1'b0);
    wait_until(f + 10);
    chk_level("dropout_rel", 1'b0);

    // reset during a hold: full debounce again, new press
    @(negedge clk);
    e = cyc + 1;
    raw = 1'b1;
    push_both(e + 6, 1'b1, 1'b0, 1'b1);
    wait_until(e + 8);
    resetN = 1'b0;
    r = e + 9;
    wait_until(r);
    chk_idle("midreset");
    resetN = 1'b1;
    push_both(r + 7, 1'b1, 1'b0, 1'b1);
    push(1, r + 7 + RD, 1'b0, 1'b0, 1'b1);
    wait_until(r + 6);
    chk_level("midreset_pre", 1'b0);
    wait_until(r + 17);
    raw = 1'b0;
    f = r + 18;
    push_both(f + 6, 1'b0, 1'b1, 1'b0);
    wait_until(f + 12);

    check_eq("q0_left", W'(exp0_q.size()), '0);
    check_eq("q1_left", W'(exp1_q.size()), '0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
